// File: rtl/pc_branch_sequencer_if.sv
// rtl/pc_branch_sequencer_if.sv - bus bundle for the PC branch sequencer
//
// Purpose: groups the table-load stream, decode/ALU inputs and PC/status
// outputs of pc_branch_sequencer into one interface.
// Ports (signals):
//   Cfg_valid/Cfg_data/Cfg_ready : table-load stream (ready only while loading)
//   Load_done                    : table fully loaded
//   Start, Halt_in, Stall        : execution control
//   Jump_en, Branch_en, Taken    : decode / ALU redirect controls
//   Idx                          : target table index
//   PC, Running, Done            : program counter and state flags
//   Redirect_cnt                 : saturating redirect counter
// Modports: master drives the inputs (decoder/loader side), slave is the sequencer.
interface pc_branch_sequencer_if #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 5
);
  logic             Cfg_valid;
  logic [PC_W-1:0]  Cfg_data;
  logic             Cfg_ready;
  logic             Load_done;
  logic             Start;
  logic             Halt_in;
  logic             Stall;
  logic             Jump_en;
  logic             Branch_en;
  logic             Taken;
  logic [IDX_W-1:0] Idx;
  logic [PC_W-1:0]  PC;
  logic             Running;
  logic             Done;
  logic [15:0]      Redirect_cnt;

  modport master (
    output Cfg_valid, Cfg_data, Start, Halt_in, Stall,
           Jump_en, Branch_en, Taken, Idx,
    input  Cfg_ready, Load_done, PC, Running, Done, Redirect_cnt
  );

  modport slave (
    input  Cfg_valid, Cfg_data, Start, Halt_in, Stall,
           Jump_en, Branch_en, Taken, Idx,
    output Cfg_ready, Load_done, PC, Running, Done, Redirect_cnt
  );
endinterface

// File: rtl/pc_branch_sequencer.sv
// rtl/pc_branch_sequencer.sv - program counter sequencer with loadable branch target table
//
// Purpose: after reset, accepts ENTRIES table words over the Cfg stream, then
// waits for Start and steps the PC each cycle: increment, absolute jump to
// table[Idx], or relative taken branch PC + table[Idx]. Counts redirects.
// Ports:
//   Clk      : clock, all state updates on the rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : pc_branch_sequencer_if.slave (stream, decode inputs, PC/status)
module pc_branch_sequencer #(
  parameter int PC_W    = 16,
  parameter int IDX_W   = 5,
  parameter int ENTRIES = 32
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  pc_branch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_LOAD       = 2'd0,
    S_WAIT_START = 2'd1,
    S_RUN        = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [15:0]      cnt_sat;
  logic             tbl_we;
  logic             cfg_ready;
  logic [PC_W-1:0]  tbl_rd;

  // Table is intentionally not reset; it is always fully reloaded after reset.
  logic [PC_W-1:0]  table_q [ENTRIES];

  assign cfg_ready = (state_q == S_LOAD);
  assign tbl_rd    = table_q[bus.Idx];
  assign cnt_sat   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_LOAD;
      ptr_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gated by Reset_n so no beat lands in the table while reset is held.
  always_ff @(posedge Clk) begin
    if (tbl_we && Reset_n) begin
      table_q[ptr_q] <= bus.Cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    tbl_we  = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (bus.Cfg_valid && cfg_ready) begin
          tbl_we = 1'b1;
          if (ptr_q == LAST_IDX) begin
            ptr_d   = '0;
            state_d = S_WAIT_START;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
      end

      S_WAIT_START, S_HALT: begin
        if (bus.Start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        if (bus.Halt_in) begin
          state_d = S_HALT;
        end else if (bus.Stall) begin
          pc_d = pc_q;
        end else if (bus.Jump_en) begin
          pc_d  = tbl_rd;
          cnt_d = cnt_sat;
        end else if (bus.Branch_en && bus.Taken) begin
          // Two's complement offset; the sum wraps naturally at PC_W bits.
          pc_d  = pc_q + tbl_rd;
          cnt_d = cnt_sat;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  assign bus.Cfg_ready    = cfg_ready;
  assign bus.Load_done    = (state_q != S_LOAD);
  assign bus.PC           = pc_q;
  assign bus.Running      = (state_q == S_RUN);
  assign bus.Done         = (state_q == S_HALT);
  assign bus.Redirect_cnt = cnt_q;

endmodule
